// File: rtl/result_serializer_pkg.sv
// Shared constants, state encodings and sizing helper for the result serializer.
// Holds the UART byte width used by the transmitter handshake.
package result_serializer_pkg;

   localparam int DATA_W = 16;
   localparam int MAX_N  = 15;
   localparam int ADDR_W = 8;
   localparam int BYTE_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_SEND_HI,
      ST_SEND_LO,
      ST_NEXT,
`ifdef RESULT_CHECKSUM_EN
      ST_SEND_CK,
`endif
      ST_FIN
   } ser_state_e;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_SEND,
      HS_ACK,
      HS_WAIT
   } hs_state_e;

   // Element count for a requested dimension, clamped to MAX_N; 15*15 fits in 8 bits.
   function automatic logic [7:0] frame_total(input logic [3:0] size);
      logic [7:0] n;
      n = (size > 4'(MAX_N)) ? 8'(MAX_N) : {4'd0, size};
      return n * n;
   endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Control, result-RAM read port and UART handshake signals of the result serializer.
// master = serializer side, slave = controller/RAM/UART side.
interface result_serializer_if;
   import result_serializer_pkg::*;

   logic                start;
   logic [3:0]          matrix_size;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rd_data;
   logic [BYTE_W-1:0]   tx_data;
   logic                tx_start;
   logic                tx_busy;
   logic                busy;
   logic                done;

   modport master (
      input  start, matrix_size, rd_data, tx_busy,
      output rd_en, rd_addr, tx_data, tx_start, busy, done
   );

   modport slave (
      output start, matrix_size, rd_data, tx_busy,
      input  rd_en, rd_addr, tx_data, tx_start, busy, done
   );

endinterface

// File: rtl/result_serializer_tx_byte_handshake.sv
// Sends one byte over the UART start/busy handshake: SEND (wait idle), ACK (busy rises), WAIT (busy falls).
// Latency: tx_start one cycle after req when idle; stalls indefinitely while tx_busy is high, byte_done when it falls.
module result_serializer_tx_byte_handshake
   import result_serializer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_data,
   output logic              byte_done
);

   hs_state_e         state_q, state_d;
   logic [BYTE_W-1:0] pend_q, pend_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;

   // tx_data only changes when a new byte is launched, so it stays put through a busy stall.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      if (req) begin
         if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = byte_in;
            state_d    = HS_ACK;
         end else begin
            pend_d  = byte_in;
            state_d = HS_SEND;
         end
      end else begin
         case (state_q)
            HS_SEND: if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = pend_q;
               state_d    = HS_ACK;
            end
            HS_ACK:  if (tx_busy)  state_d = HS_WAIT;
            HS_WAIT: if (!tx_busy) state_d = HS_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HS_IDLE;
         pend_q     <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign byte_done = (state_q == HS_WAIT) && !tx_busy;

endmodule

// File: rtl/result_serializer.sv
// Streams the N*N result matrix row-major as MSB/LSB byte pairs to the UART; optional XOR byte with RESULT_CHECKSUM_EN.
// Latency: start -> first tx_start 3 cycles; backpressure via tx_busy, held indefinitely with no timeout.
module result_serializer
   import result_serializer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   result_serializer_if.master bus
);

   ser_state_e        state_q, state_d;
   logic [7:0]        total_q, total_d;
   logic [7:0]        idx_q, idx_d;
   logic [DATA_W-1:0] elem_q, elem_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef RESULT_CHECKSUM_EN
   logic [BYTE_W-1:0] ck_q, ck_d;
`endif

   logic              hs_req;
   logic [BYTE_W-1:0] hs_byte;
   logic              hs_done;

   always_comb begin
      state_d   = state_q;
      total_d   = total_q;
      idx_d     = idx_q;
      elem_d    = elem_q;
      rd_addr_d = rd_addr_q;
      hs_req    = 1'b0;
      hs_byte   = elem_q[BYTE_W-1:0];
      case (state_q)
         ST_IDLE: if (bus.start) begin
            total_d = frame_total(bus.matrix_size);
            idx_d   = '0;
            state_d = (total_d == 8'd0) ? ST_FIN : ST_FETCH;
         end
         ST_FETCH: state_d = ST_LATCH;
         // RAM data is valid this cycle; the high byte goes straight to the handshake.
         ST_LATCH: begin
            elem_d  = bus.rd_data;
            hs_req  = 1'b1;
            hs_byte = bus.rd_data[DATA_W-1 -: BYTE_W];
            state_d = ST_SEND_HI;
         end
         ST_SEND_HI: if (hs_done) begin
            hs_req  = 1'b1;
            hs_byte = elem_q[BYTE_W-1:0];
            state_d = ST_SEND_LO;
         end
         ST_SEND_LO: if (hs_done) state_d = ST_NEXT;
         ST_NEXT: begin
            if (idx_q == total_q - 8'd1) begin
`ifdef RESULT_CHECKSUM_EN
               hs_req  = 1'b1;
               hs_byte = ck_q;
               state_d = ST_SEND_CK;
`else
               state_d = ST_FIN;
`endif
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = ST_FETCH;
            end
         end
`ifdef RESULT_CHECKSUM_EN
         ST_SEND_CK: if (hs_done) state_d = ST_FIN;
`endif
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      rd_en_d = (state_d == ST_FETCH);
      if (state_d == ST_FETCH) rd_addr_d = ADDR_W'(idx_d);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_q == ST_FIN);
`ifdef RESULT_CHECKSUM_EN
      ck_d = (state_q == ST_IDLE) ? '0 : (hs_req ? (ck_q ^ hs_byte) : ck_q);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         total_q   <= '0;
         idx_q     <= '0;
         elem_q    <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
         ck_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         total_q   <= total_d;
         idx_q     <= idx_d;
         elem_q    <= elem_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef RESULT_CHECKSUM_EN
         ck_q      <= ck_d;
`endif
      end
   end

   result_serializer_tx_byte_handshake u_tx_hs (
      .clk       (clk),
      .rst       (rst),
      .req       (hs_req),
      .byte_in   (hs_byte),
      .tx_busy   (bus.tx_busy),
      .tx_start  (bus.tx_start),
      .tx_data   (bus.tx_data),
      .byte_done (hs_done)
   );

   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
